fadd_share_ctrl: RTL
====================

Name: fadd_share_ctrl

Overview:
Shares one single-precision fadd unit between NREQ requesters using round-robin arbitration with valid/ready handshakes. Each accepted operation is tagged with its requester ID and tracked through the fadd latency. Results land in a small in-order result queue with downstream backpressure. The block sits between the FPU's clients (core issue ports) and the fadd instance, which it drives through its a/b/c ports.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, equal to $clog2(NREQ)
FADD_LAT, 1, cycles from operands applied to fadd a/b until fadd c is valid (fadd registers inputs, output combinational)
RQ_DEPTH, 2, result queue depth and credit limit, at least FADD_LAT+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester operation valid
req_a  in  NREQ*32  per-requester operand a; slice i is [32*i+31:32*i]
req_b  in  NREQ*32  per-requester operand b, same packing
req_ready  out  NREQ  per-requester accept; one-hot or zero
fadd_a  out  32  to fadd input a
fadd_b  out  32  to fadd input b
fadd_c  in  32  from fadd output c
rsp_valid  out  1  result queue head valid
rsp_ready  in  1  downstream accepts head
rsp_id  out  IDW  requester ID of head
rsp_data  out  32  fadd result of head
busy  out  1  operations issued and not yet popped

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high.
- Reset state: ptr=0, cnt=0, tag pipeline valids=0, queue empty.
  - Outputs under reset: rsp_valid=0, req_ready=0, busy=0, fadd_a=fadd_b=0.
  - rst mid-operation discards in-flight and queued results. fadd_c is ignored until new issues.
- Credit counter cnt (0..RQ_DEPTH) counts ops issued but not popped.
  - pop = rsp_valid & rsp_ready.
  - can_issue = (cnt < RQ_DEPTH) | pop.
  - cnt += issue, cnt -= pop. Simultaneous issue and pop leaves cnt unchanged.
- Arbitration (combinational, same cycle):
  - If can_issue, grant the first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
  - req_ready[g]=1 for the granted requester only.
  - issue = any grant. On issue, ptr <= (g+1) mod NREQ. ptr holds when there is no issue.
- Requester rules: a requester must hold req_a/req_b stable while valid & !ready. Dropping valid before acceptance is permitted.
- Operand drive: fadd_a/fadd_b = granted slices when issuing, else 0. Idle cycles pass 0+0 through fadd; no tag is attached, so those results are ignored.
- Tag pipeline: FADD_LAT-stage shift register of {v,id}.
  - Stage 0 loads {issue,g} at the issuing edge.
  - When the last stage is valid, fadd_c is pushed with its id into the queue on the following edge.
  - With FADD_LAT=1: issue at edge N; fadd_c is valid during cycle N+1; the push happens at edge N+1; rsp_valid rises in cycle N+2.
- Result queue: FIFO of {id,data}, depth RQ_DEPTH, in issue order.
  - rsp_* driven from the head.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by credit. Assert cnt ≤ RQ_DEPTH and never push when full without pop.
- rsp_data is fadd_c unmodified, including NaN=0x7fffffff, ±inf and zero.
- busy = (cnt != 0).
- Throughput: one op per cycle sustained while rsp_ready=1 and RQ_DEPTH ≥ FADD_LAT+1.

Decomposition:
- Package fpu_pkg holds:
  - FP_W=32, FADD_LAT=1.
  - Constants FP_QNAN=32'h7fffffff, FP_PINF=32'h7f800000, FP_NINF=32'hff800000.
  - typedef struct packed {logic[IDW-1:0] id; logic[31:0] data;} fadd_rsp_t, parameterised via a localparam IDW_MAX=3.
- Sub-module rr_arbiter (NREQ): inputs req, en, ptr; outputs one-hot gnt, encoded idx, any.
- The FIFO stays inline: two entries, with rd/wr pointers and a count.

Test Plan:
1. rst then req0 {0x3f800000, 0x40000000}, rsp_ready=1 -> req_ready[0] same cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_data=0x40400000; busy drops after the pop.
2. All 4 valid every cycle, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; responses carry ids in the same order, one per cycle.
3. req2 {0x7f800000, 0xff800000} -> rsp_data=0x7fffffff, id=2. req1 {0x3fc00000, 0xbfc00000} -> rsp_data=0x00000000.
4. rsp_ready=0, req0 continuously valid -> exactly 2 accepts, then req_ready=0 with cnt=2. rsp_ready=1 -> both results pop in order and issue resumes the same cycle as the first pop.
5. Issue 2 ops, assert rst for 1 cycle during flight -> rsp_valid=0, busy=0 after reset, no stale response appears later; ptr restarts at 0.
6. Only req3 valid, with ptr=0 -> granted immediately; next ptr=0 (wraps), so req0 wins the next contention against req3.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU constants and the tagged fadd response record.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int FADD_LAT = 1;
  localparam int IDW_MAX  = 3;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7fffffff;
  localparam logic [FP_W-1:0] FP_PINF = 32'h7f800000;
  localparam logic [FP_W-1:0] FP_NINF = 32'hff800000;

  // The id field is sized for the largest supported requester count (8).
  typedef struct packed {
    logic [IDW_MAX-1:0] id;
    logic [FP_W-1:0]    data;
  } fadd_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  // Search ptr, ptr+1, ... modulo NREQ and stop at the first requester.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (en && !any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = IDW'(cand);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_share_ctrl.sv
// Shares one fadd unit between NREQ requesters: round-robin issue, id tag
// pipeline matching the fadd latency, and an in-order credit-limited
// result queue.
module fadd_share_ctrl
  import fpu_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = $clog2(NREQ),
  parameter int FADD_LAT = fpu_pkg::FADD_LAT,
  parameter int RQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       fadd_a,
  output logic [31:0]       fadd_b,
  input  logic [31:0]       fadd_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(RQ_DEPTH + 1);
  localparam int PTR_W = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RQ_DEPTH - 1);

  logic [IDW-1:0]   ptr;
  logic [CNT_W-1:0] cnt;
  logic             pop;
  logic             can_issue;
  logic             issue;
  logic [IDW-1:0]   gnt_idx;
  logic [NREQ-1:0]  gnt;

  logic [FADD_LAT-1:0] tag_v;
  logic [IDW-1:0]      tag_id [FADD_LAT];
  logic                push;

  fadd_rsp_t        q_mem [RQ_DEPTH];
  fadd_rsp_t        q_head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] q_cnt;
  logic             q_full;

  // Issue is blocked during reset and whenever no credit is left.
  assign pop       = rsp_valid & rsp_ready;
  assign can_issue = (cnt < CNT_MAX) | pop;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .en  (can_issue & ~rst),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (issue)
  );

  assign req_ready = gnt;

  // Steer the granted operands to the fadd; idle cycles feed 0+0.
  always_comb begin
    fadd_a = '0;
    fadd_b = '0;
    if (issue) begin
      fadd_a = req_a[32*gnt_idx +: 32];
      fadd_b = req_b[32*gnt_idx +: 32];
    end
  end

  // Round-robin pointer moves past the winner only when something issues.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst)
      ptr <= '0;
    else if (issue)
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  // Credit counter: ops issued and not yet popped downstream.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (issue && !pop)
      cnt <= cnt + CNT_W'(1);
    else if (!issue && pop)
      cnt <= cnt - CNT_W'(1);
  end

  // Valid bits of the tag pipeline shadow ops travelling through the fadd.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= issue;
      for (int k = 1; k < FADD_LAT; k++) tag_v[k] <= tag_v[k-1];
    end
  end

  // Requester ids follow their valid bits; stale ids are masked by tag_v.
  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_idx;
    for (int k = 1; k < FADD_LAT; k++) tag_id[k] <= tag_id[k-1];
  end

  assign push   = tag_v[FADD_LAT-1];
  assign q_full = (q_cnt == CNT_MAX);

  // Result queue storage: written on push, read at rd_ptr.
  always_ff @(posedge clk) begin
    // NOTE: queue storage has no reset; q_cnt alone decides what is valid.
    if (push) q_mem[wr_ptr] <= '{id: IDW_MAX'(tag_id[FADD_LAT-1]), data: fadd_c};
  end

  // Queue pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)
        q_cnt <= q_cnt + CNT_W'(1);
      else if (!push && pop)
        q_cnt <= q_cnt - CNT_W'(1);
    end
  end

  assign q_head    = q_mem[rd_ptr];
  assign rsp_valid = ~rst & (q_cnt != '0);
  assign rsp_id    = q_head.id[IDW-1:0];
  assign rsp_data  = q_head.data;
  assign busy      = ~rst & (cnt != '0);

  // Credit accounting guarantees these never fire.
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_MAX);
  a_no_ovf:    assert property (@(posedge clk) disable iff (rst) !(push && q_full && !pop));
  a_head_id:   assert property (@(posedge clk) disable iff (rst)
                                !rsp_valid || (q_head.id < IDW_MAX'(NREQ)));

endmodule
